// File: rtl/rapids_mem_arbiter_if.sv
// rtl/rapids_mem_arbiter_if.sv - fetch, data and memory port bundle for rapids_mem_arbiter
interface rapids_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      if_req;
   logic [ADDR_WIDTH-1:0]     if_addr;
   logic [DATA_WIDTH-1:0]     if_rdata;
   logic                      if_done;
   logic                      d_req;
   logic                      d_we;
   logic [ADDR_WIDTH-1:0]     d_addr;
   logic [DATA_WIDTH-1:0]     d_wdata;
   logic [DATA_WIDTH/8-1:0]   d_be;
   logic [DATA_WIDTH-1:0]     d_rdata;
   logic                      d_done;
   logic                      mem_req;
   logic                      mem_we;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [DATA_WIDTH/8-1:0]   mem_be;
   logic [DATA_WIDTH-1:0]     mem_rdata;
   logic                      mem_ready;
   logic                      bus_err;

   // Arbiter side.
   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
      output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
   );

   // Requester and memory side.
   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
      input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
   );
endinterface

// File: rtl/rapids_mem_arbiter.sv
// rtl/rapids_mem_arbiter.sv - shares one memory port between fetch and load/store with data priority
module rapids_mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  halt,
   rapids_mem_arbiter_if.master  bus
);
   localparam int BW = DATA_WIDTH / 8;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, MEM_F, MEM_D, DONE_F, DONE_D} state_t;

   state_t                state, state_n;
   logic [SW-1:0]         starve_cnt, starve_n;
   logic [WW-1:0]         wait_cnt, wait_n;
   logic                  mem_req_q, mem_req_n;
   logic                  mem_we_q, mem_we_n;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_n;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_n;
   logic [BW-1:0]         mem_be_q, mem_be_n;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_n;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_n;
   logic                  if_done_q, if_done_n;
   logic                  d_done_q, d_done_n;
   logic                  bus_err_q, bus_err_n;
   logic                  tout;

   always_comb begin
      state_n     = state;
      starve_n    = starve_cnt;
      wait_n      = wait_cnt;
      mem_req_n   = mem_req_q;
      mem_we_n    = mem_we_q;
      mem_addr_n  = mem_addr_q;
      mem_wdata_n = mem_wdata_q;
      mem_be_n    = mem_be_q;
      if_rdata_n  = if_rdata_q;
      d_rdata_n   = d_rdata_q;
      if_done_n   = 1'b0;
      d_done_n    = 1'b0;
      bus_err_n   = 1'b0;
      tout        = 1'b0;
      case (state)
         IDLE: begin
            if (!halt) begin
               if (bus.if_req && (!bus.d_req || starve_cnt == SW'(STARVE_LIMIT))) begin
                  state_n     = MEM_F;
                  mem_req_n   = 1'b1;
                  mem_we_n    = 1'b0;
                  mem_addr_n  = bus.if_addr;
                  mem_wdata_n = '0;
                  mem_be_n    = '1;
                  starve_n    = '0;
                  wait_n      = '0;
               end else if (bus.d_req) begin
                  state_n     = MEM_D;
                  mem_req_n   = 1'b1;
                  mem_we_n    = bus.d_we;
                  mem_addr_n  = bus.d_addr;
                  mem_wdata_n = bus.d_wdata;
                  mem_be_n    = bus.d_be;
                  wait_n      = '0;
                  // Only a data grant that bypasses a waiting fetch counts toward starvation.
                  if (!bus.if_req)
                     starve_n = '0;
                  else if (starve_cnt != SW'(STARVE_LIMIT))
                     starve_n = starve_cnt + 1'b1;
               end
            end
         end
         MEM_F, MEM_D: begin
            tout = !bus.mem_ready && (wait_cnt == WW'(TIMEOUT - 1));
            if (bus.mem_ready || tout) begin
               mem_req_n = 1'b0;
               bus_err_n = tout;
               if (state == MEM_F) begin
                  if_rdata_n = tout ? '0 : bus.mem_rdata;
                  if_done_n  = 1'b1;
                  state_n    = DONE_F;
               end else begin
                  d_rdata_n  = tout ? '0 : bus.mem_rdata;
                  d_done_n   = 1'b1;
                  state_n    = DONE_D;
               end
            end else begin
               wait_n = wait_cnt + 1'b1;
            end
         end
         DONE_F, DONE_D: state_n = IDLE;
         default:        state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         wait_cnt    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state       <= state_n;
         starve_cnt  <= starve_n;
         wait_cnt    <= wait_n;
         mem_req_q   <= mem_req_n;
         mem_we_q    <= mem_we_n;
         mem_addr_q  <= mem_addr_n;
         mem_wdata_q <= mem_wdata_n;
         mem_be_q    <= mem_be_n;
         if_rdata_q  <= if_rdata_n;
         d_rdata_q   <= d_rdata_n;
         if_done_q   <= if_done_n;
         d_done_q    <= d_done_n;
         bus_err_q   <= bus_err_n;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.d_done    = d_done_q;
   assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_rapids_mem_arbiter.sv
// tb/tb_rapids_mem_arbiter.sv - directed self-checking bench for rapids_mem_arbiter
module tb_rapids_mem_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   logic halt;
   int   tests = 0;
   int   fails = 0;

   rapids_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   rapids_mem_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .halt(halt), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      string exp_order;
      byte   got;
      int    n;
      reset_n = 1'b0;
      halt    = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
      bus.mem_rdata = '0; bus.mem_ready = 1'b0;
      tick; tick;
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_be", bus.mem_be, 0);
      chk("rst_if_done", bus.if_done, 0);
      chk("rst_d_done", bus.d_done, 0);
      chk("rst_bus_err", bus.bus_err, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      reset_n = 1'b1;

      // Single fetch, memory answers one cycle after mem_req
      bus.if_req = 1'b1; bus.if_addr = 32'd0;
      tick;
      chk("f_mem_req", bus.mem_req, 1);
      chk("f_mem_we", bus.mem_we, 0);
      chk("f_mem_be", bus.mem_be, 4'hF);
      tick;
      chk("f_no_early_done", bus.if_done, 0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h9EF10004;
      tick;
      chk("f_if_done", bus.if_done, 1);
      chk("f_if_rdata", bus.if_rdata, 32'h9EF10004);
      chk("f_mem_req_drop", bus.mem_req, 0);
      bus.if_req = 1'b0; bus.mem_ready = 1'b0;
      tick;
      chk("f_done_pulse", bus.if_done, 0);
      tick;
      chk("f_idle", bus.mem_req, 0);

      // Store then load
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd64; bus.d_wdata = 32'd10; bus.d_be = 4'hF;
      tick;
      chk("st_mem_we", bus.mem_we, 1);
      chk("st_mem_wdata", bus.mem_wdata, 32'd10);
      chk("st_mem_addr", bus.mem_addr, 32'd64);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000DEAD;
      tick;
      chk("st_d_done", bus.d_done, 1);
      bus.d_req = 1'b0; bus.mem_ready = 1'b0;
      tick;
      bus.d_req = 1'b1; bus.d_we = 1'b0;
      tick;
      chk("ld_mem_we", bus.mem_we, 0);
      chk("ld_mem_addr", bus.mem_addr, 32'd64);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'd10;
      tick;
      chk("ld_d_done", bus.d_done, 1);
      chk("ld_d_rdata", bus.d_rdata, 32'd10);
      bus.d_req = 1'b0; bus.mem_ready = 1'b0;
      tick;

      // Contention: fetch gets through after four data grants
      exp_order = "DDDDFDDDDF";
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      bus.d_req = 1'b1; bus.d_addr = 32'h80;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234;
      for (int i = 0; i < 10; i++) begin
         n = 0;
         while (!(bus.if_done || bus.d_done) && n < 8) begin
            tick;
            n++;
            if (bus.if_done || bus.d_done) break;
         end
         got = bus.if_done ? "F" : (bus.d_done ? "D" : "-");
         chk($sformatf("order_%0d", i), got, exp_order[i]);
         if (got == "-") break;
         tick;
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0;
      tick; tick;

      // Timeout on a load
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd8;
      tick;
      chk("to_mem_req", bus.mem_req, 1);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         tick;
         n++;
         if (!bus.mem_req) break;
      end
      chk("to_cycles", n, 16);
      chk("to_d_done", bus.d_done, 1);
      chk("to_bus_err", bus.bus_err, 1);
      chk("to_d_rdata", bus.d_rdata, 0);
      bus.d_req = 1'b0;
      tick;
      chk("to_err_pulse", bus.bus_err, 0);
      chk("to_done_pulse", bus.d_done, 0);

      // Halt during a fetch
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      tick;
      chk("h_grant", bus.mem_addr, 32'h100);
      halt = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h200;
      tick;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55;
      tick;
      chk("h_if_done", bus.if_done, 1);
      chk("h_if_rdata", bus.if_rdata, 32'h55);
      bus.if_req = 1'b0; bus.mem_ready = 1'b0;
      tick;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("h_no_grant_%0d", k), bus.mem_req, 0);
      end
      halt = 1'b0;
      tick;
      chk("h_resume_req", bus.mem_req, 1);
      chk("h_resume_addr", bus.mem_addr, 32'h200);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h66;
      tick;
      chk("h_d_rdata", bus.d_rdata, 32'h66);
      bus.d_req = 1'b0; bus.mem_ready = 1'b0;
      tick;

      // Reset in the middle of a data transaction
      bus.d_req = 1'b1; bus.d_addr = 32'h4;
      tick;
      chk("r_mem_req", bus.mem_req, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("r_async_mem_req", bus.mem_req, 0);
      chk("r_async_d_rdata", bus.d_rdata, 0);
      bus.d_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
      tick;
      chk("r_no_done_rst", bus.d_done, 0);
      reset_n = 1'b1;
      tick;
      chk("r_no_done_after", bus.d_done, 0);
      chk("r_idle", bus.mem_req, 0);
      bus.d_req = 1'b1;
      tick;
      chk("r_resume_req", bus.mem_req, 1);
      tick;
      chk("r_resume_done", bus.d_done, 1);
      chk("r_resume_rdata", bus.d_rdata, 32'h77);
      bus.d_req = 1'b0; bus.mem_ready = 1'b0;
      tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
